// File: rtl/buffer_window_checker.sv
// Purpose : self-timed checker for circular-buffer capture runs; compares beats in a window
// Latency : mismatch/count results are registered on the beat edge, visible one cycle later
// Backpr. : none; beats are taken only on sample_en, gaps of any length are tolerated
//
// Ports:
//   clk, reset_n            clock (rising edge) and asynchronous active-low reset
//   start                   1-cycle pulse: clear results and begin a new run
//   sample_en               beat strobe; data ports are looked at only when high
//   data_in                 stimulus written into the buffer
//   data_out                buffer output after the delay line
//   test_failed             sticky mismatch flag
//   error_count             saturating count of mismatching beats
//   checked_count           number of beats compared in this run
//   first_fail_index        beat index of the first mismatch
//   first_fail_data         data_out seen at the first mismatch
//   first_fail_expected     data_in (expected value) at the first mismatch
//   done                    run complete (level, held until start or reset)
//   pass                    done and no mismatch seen
module buffer_window_checker #(
   parameter int DATA_WIDTH      = 8,
   parameter int MEMORY_SIZE     = 16,
   parameter int USER_HOLDOFF    = 4,
   parameter int ALIGNMENT_DELAY = 2,
   parameter int CNT_WIDTH       = 16,
   parameter int ERR_WIDTH       = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  sample_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [DATA_WIDTH-1:0] data_out,
   output logic                  test_failed,
   output logic [ERR_WIDTH-1:0]  error_count,
   output logic [CNT_WIDTH-1:0]  checked_count,
   output logic [CNT_WIDTH-1:0]  first_fail_index,
   output logic [DATA_WIDTH-1:0] first_fail_data,
   output logic [DATA_WIDTH-1:0] first_fail_expected,
   output logic                  done,
   output logic                  pass
);

   // Window bounds in beats counted from the start pulse.
   localparam int WS     = MEMORY_SIZE + USER_HOLDOFF + ALIGNMENT_DELAY;
   localparam int WE     = WS + MEMORY_SIZE;
   localparam int OFFSET = MEMORY_SIZE + ALIGNMENT_DELAY;

   localparam logic [CNT_WIDTH-1:0]  WS_C     = CNT_WIDTH'(WS);
   localparam logic [CNT_WIDTH-1:0]  WE_C     = CNT_WIDTH'(WE);
   // The delay line offset only matters modulo the data width.
   localparam logic [DATA_WIDTH-1:0] OFFSET_C = DATA_WIDTH'(OFFSET);
   localparam logic [ERR_WIDTH-1:0]  ERR_MAX  = {ERR_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [CNT_WIDTH-1:0]    beat_cnt;
   logic [CNT_WIDTH-1:0]    beat_inc;
   logic                    count_en;
   logic                    cmp_en;
   logic [DATA_WIDTH-1:0]   rebuilt;
   logic                    mismatch;

   assign beat_inc = beat_cnt + 1'b1;

   // Buffer output plus the delay-line offset should reproduce the stimulus;
   // the sum wraps silently at the data width.
   assign rebuilt  = data_out + OFFSET_C;
   assign mismatch = cmp_en && (data_in != rebuilt);

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic. start takes priority over any beat in the same cycle,
   // and that beat is discarded rather than counted.
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state;
      count_en   = 1'b0;
      cmp_en     = 1'b0;
      if (start) begin
         state_next = (WS == 0) ? S_CHECK : S_WAIT;
      end else if (sample_en) begin
         case (state)
            S_WAIT: begin
               count_en = 1'b1;
               if (beat_inc == WS_C) begin
                  state_next = S_CHECK;
               end
            end
            S_CHECK: begin
               count_en = 1'b1;
               cmp_en   = 1'b1;
               // The closing beat is still compared before the run ends.
               if (beat_inc == WE_C) begin
                  state_next = S_DONE;
               end
            end
            default: begin
               state_next = state;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Beat counter
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         beat_cnt <= '0;
      end else if (start) begin
         beat_cnt <= '0;
      end else if (count_en) begin
         beat_cnt <= beat_inc;
      end
   end

   // ---------------------------------------------------------------------
   // Result registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         test_failed         <= 1'b0;
         error_count         <= '0;
         checked_count       <= '0;
         first_fail_index    <= '0;
         first_fail_data     <= '0;
         first_fail_expected <= '0;
         done                <= 1'b0;
      end else if (start) begin
         test_failed         <= 1'b0;
         error_count         <= '0;
         checked_count       <= '0;
         first_fail_index    <= '0;
         first_fail_data     <= '0;
         first_fail_expected <= '0;
         done                <= 1'b0;
      end else begin
         done <= (state_next == S_DONE);
         if (cmp_en) begin
            checked_count <= checked_count + 1'b1;
         end
         if (mismatch) begin
            test_failed <= 1'b1;
            if (error_count != ERR_MAX) begin
               error_count <= error_count + 1'b1;
            end
            // test_failed is still clear only for the first mismatch of the run.
            if (!test_failed) begin
               first_fail_index    <= beat_inc;
               first_fail_data     <= data_out;
               first_fail_expected <= data_in;
            end
         end
      end
   end

   assign pass = done & ~test_failed;

endmodule

// File: tb/tb_buffer_window_checker.sv
module tb_buffer_window_checker;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        start_b = 1'b0;
   logic        sample_en = 1'b0;
   logic [7:0]  data_in = '0;
   logic [7:0]  data_out = '0;

   logic        test_failed, done, pass;
   logic [7:0]  error_count, ff_data, ff_exp;
   logic [15:0] checked_count, ff_index;

   logic        b_test_failed, b_done, b_pass;
   logic [7:0]  b_error_count, b_ff_data, b_ff_exp;
   logic [15:0] b_checked_count, b_ff_index;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   buffer_window_checker dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .start               (start),
      .sample_en           (sample_en),
      .data_in             (data_in),
      .data_out            (data_out),
      .test_failed         (test_failed),
      .error_count         (error_count),
      .checked_count       (checked_count),
      .first_fail_index    (ff_index),
      .first_fail_data     (ff_data),
      .first_fail_expected (ff_exp),
      .done                (done),
      .pass                (pass)
   );

   // Long window instance: WS=306, WE=606, OFFSET=302 (46 mod 256).
   buffer_window_checker #(.MEMORY_SIZE(300)) dut_big (
      .clk                 (clk),
      .reset_n             (reset_n),
      .start               (start_b),
      .sample_en           (sample_en),
      .data_in             (data_in),
      .data_out            (data_out),
      .test_failed         (b_test_failed),
      .error_count         (b_error_count),
      .checked_count       (b_checked_count),
      .first_fail_index    (b_ff_index),
      .first_fail_data     (b_ff_data),
      .first_fail_expected (b_ff_exp),
      .done                (b_done),
      .pass                (b_pass)
   );

   typedef struct {
      bit         st;
      bit         en;
      logic [7:0] din;
      logic [7:0] dout;
      bit         tf;
      logic [7:0] err;
      logic [15:0] chk;
      bit         dn;
      bit         ps;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at a falling edge: drive inputs, let one rising edge pass,
   // return at the next falling edge with outputs settled.
   task automatic cyc(input bit st, input bit en, input logic [7:0] din, input logic [7:0] dout);
      start     = st;
      sample_en = en;
      data_in   = din;
      data_out  = dout;
      @(negedge clk);
      start     = 1'b0;
      sample_en = 1'b0;
   endtask

   task automatic add(input bit st, input bit en, input logic [7:0] din, input logic [7:0] dout,
                      input bit tf, input logic [7:0] err, input logic [15:0] chk,
                      input bit dn, input bit ps);
      vec_t v;
      v.st = st; v.en = en; v.din = din; v.dout = dout;
      v.tf = tf; v.err = err; v.chk = chk; v.dn = dn; v.ps = ps;
      tbl.push_back(v);
   endtask

   // Adds a start row plus 40 clean-result beats. mode 0: din=k, dout=k-18;
   // mode 1: same but beats 5, 22, 39 corrupted; mode 2: din=k+240, dout=k+222.
   task automatic add_run(input int mode);
      logic [7:0] di, dq;
      logic [15:0] c;
      add(1'b1, 1'b1, 8'h55, 8'h00, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0);
      for (int k = 1; k <= 40; k++) begin
         di = (mode == 2) ? 8'(k + 240) : 8'(k);
         dq = (mode == 2) ? 8'(k + 222) : 8'(k - 18);
         if (mode == 1 && (k == 5 || k == 22 || k == 39)) dq = dq ^ 8'h80;
         c = (k <= 22) ? 16'd0 : (k >= 38) ? 16'd16 : 16'(k - 22);
         add(1'b0, 1'b1, di, dq, 1'b0, 8'd0, c, k >= 38, k >= 38);
      end
   endtask

   initial begin
      @(negedge clk);
      // Reset state, with inputs active to show they are ignored in reset.
      start = 1'b1; sample_en = 1'b1;
      @(negedge clk);
      check("rst_tf", test_failed, 0);
      check("rst_err", error_count, 0);
      check("rst_chk", checked_count, 0);
      check("rst_idx", ff_index, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_big_done", b_done, 0);
      start = 1'b0; sample_en = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);

      // IDLE ignores beats.
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 8'(k), 8'(k));
      check("idle_chk", checked_count, 0);
      check("idle_done", done, 0);

      // Table: clean run, corruption only outside window, wrapped data.
      add_run(0);
      add_run(1);
      add_run(2);
      foreach (tbl[i]) begin
         cyc(tbl[i].st, tbl[i].en, tbl[i].din, tbl[i].dout);
         check($sformatf("tbl%0d_tf", i), test_failed, tbl[i].tf);
         check($sformatf("tbl%0d_err", i), error_count, tbl[i].err);
         check($sformatf("tbl%0d_chk", i), checked_count, tbl[i].chk);
         check($sformatf("tbl%0d_done", i), done, tbl[i].dn);
         check($sformatf("tbl%0d_pass", i), pass, tbl[i].ps);
      end

      // Single mismatch at beat 25.
      cyc(1'b1, 1'b1, 8'h00, 8'h00);
      for (int k = 1; k <= 40; k++) begin
         cyc(1'b0, 1'b1, 8'(k), (k == 25) ? (8'(k - 18) ^ 8'h01) : 8'(k - 18));
         if (k == 24) check("mm_tf_before", test_failed, 0);
         if (k == 25) begin
            check("mm_tf", test_failed, 1);
            check("mm_idx", ff_index, 25);
            check("mm_data", ff_data, 6);
            check("mm_exp", ff_exp, 25);
            check("mm_err", error_count, 1);
            check("mm_pass_early", pass, 0);
         end
      end
      check("mm_done", done, 1);
      check("mm_pass", pass, 0);
      check("mm_err_end", error_count, 1);
      check("mm_chk_end", checked_count, 16);

      // Beats every other cycle; gap cycles carry junk that must be ignored.
      cyc(1'b1, 1'b0, 8'h00, 8'h00);
      for (int k = 1; k <= 40; k++) begin
         cyc(1'b0, 1'b1, 8'(k), 8'(k - 18));
         if (k == 30) check("gap_chk30", checked_count, 8);
         if (k == 37) check("gap_done37", done, 0);
         if (k == 38) check("gap_done38", done, 1);
         cyc(1'b0, 1'b0, 8'hAA, 8'h00);
      end
      check("gap_pass", pass, 1);
      check("gap_err", error_count, 0);
      check("gap_chk", checked_count, 16);

      // Reset mid-run with a failure recorded.
      cyc(1'b1, 1'b1, 8'h00, 8'h00);
      for (int k = 1; k <= 30; k++) cyc(1'b0, 1'b1, 8'(k), (k == 25) ? 8'h00 : 8'(k - 18));
      check("pre_rst_tf", test_failed, 1);
      check("pre_rst_chk", checked_count, 8);
      reset_n = 1'b0;
      #1;
      check("arst_tf", test_failed, 0);
      check("arst_err", error_count, 0);
      check("arst_chk", checked_count, 0);
      check("arst_idx", ff_index, 0);
      check("arst_data", ff_data, 0);
      check("arst_exp", ff_exp, 0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 1; k <= 3; k++) cyc(1'b0, 1'b1, 8'(k), 8'(k - 18));
      check("post_rst_chk", checked_count, 0);
      cyc(1'b1, 1'b1, 8'h00, 8'h00);
      for (int k = 1; k <= 40; k++) cyc(1'b0, 1'b1, 8'(k), 8'(k - 18));
      check("restart_chk", checked_count, 16);
      check("restart_pass", pass, 1);

      // Two mismatches then a start pulse mid-CHECK.
      cyc(1'b1, 1'b1, 8'h00, 8'h00);
      for (int k = 1; k <= 30; k++)
         cyc(1'b0, 1'b1, 8'(k), (k == 25 || k == 27) ? 8'h00 : 8'(k - 18));
      check("two_err", error_count, 2);
      check("two_idx", ff_index, 25);
      check("two_data", ff_data, 0);
      cyc(1'b1, 1'b1, 8'h00, 8'h00);
      check("mid_start_tf", test_failed, 0);
      check("mid_start_err", error_count, 0);
      check("mid_start_chk", checked_count, 0);
      check("mid_start_idx", ff_index, 0);
      for (int k = 1; k <= 40; k++) cyc(1'b0, 1'b1, 8'(k), 8'(k - 18));
      check("mid_restart_pass", pass, 1);
      check("mid_restart_chk", checked_count, 16);

      // Long window, every beat corrupt: error count saturates.
      start_b = 1'b1;
      cyc(1'b0, 1'b1, 8'h00, 8'h00);
      start_b = 1'b0;
      for (int k = 1; k <= 606; k++) begin
         cyc(1'b0, 1'b1, 8'(k), 8'(k));
         if (k == 306) check("big_chk306", b_checked_count, 0);
         if (k == 307) begin
            check("big_err307", b_error_count, 1);
            check("big_idx", b_ff_index, 307);
         end
         if (k == 561) check("big_err561", b_error_count, 255);
         if (k == 562) check("big_err562", b_error_count, 255);
         if (k == 605) check("big_done605", b_done, 0);
      end
      check("big_err", b_error_count, 255);
      check("big_chk", b_checked_count, 300);
      check("big_done", b_done, 1);
      check("big_pass", b_pass, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
